ultrasonic_ranger: RTL and testbench



---
 rtl/ultrasonic_ranger_pkg.sv | 17 +
 rtl/ultrasonic_ranger_sync2.sv | 20 ++
 rtl/ultrasonic_ranger.sv | 127 ++++++++++++
 tb/tb_ultrasonic_ranger.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_ranger_pkg.sv
// ultrasonic_pkg: shared state encoding, result constants and default parameters
// for the ultrasonic ranger. No ports.
package ultrasonic_pkg;
    localparam int unsigned CLK_HZ_DEF        = 50_000_000;
    localparam int unsigned TRIG_MIN_DEF      = 500;
    localparam int unsigned CYCLES_PER_MM_DEF = 291;
    localparam int unsigned ECHO_TIMEOUT_DEF  = 2_000_000;

    localparam logic [31:0] DIST_TIMEOUT = 32'hFFFF_FFFF;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_TRIG = 3'd1;
    localparam state_t S_WAIT = 3'd2;
    localparam state_t S_MEAS = 3'd3;
    localparam state_t S_DONE = 3'd4;
endpackage

// File: rtl/ultrasonic_ranger_sync2.sv
// sync2: two-flop synchronizer for an asynchronous input.
// Ports: clk, rst_n (async, active-low), d (async input), q (synchronized output).
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: qualifies the sensor trigger, times the echo pulse and converts it to mm.
// Ports: clk, rst_n (async, active-low); trigger, echo (async sensor pins);
//        valid (one-cycle strobe, distance new this cycle);
//        triggerSuc (high while a qualified measurement is in progress);
//        distance (last result in mm, DIST_TIMEOUT when no echo or echo too long).
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_HZ          = CLK_HZ_DEF,
    parameter int unsigned TRIG_MIN_CYCLES = TRIG_MIN_DEF,
    parameter int unsigned CYCLES_PER_MM   = CYCLES_PER_MM_DEF,
    parameter int unsigned ECHO_TIMEOUT    = ECHO_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic        echo,
    output logic        valid,
    output logic        triggerSuc,
    output logic [31:0] distance
);
    localparam int PW = (CYCLES_PER_MM > 1) ? $clog2(CYCLES_PER_MM) : 1;

    if (CLK_HZ == 0 || TRIG_MIN_CYCLES == 0 || CYCLES_PER_MM == 0 || ECHO_TIMEOUT == 0) begin : g_bad_params
        $error("ultrasonic_ranger: parameters must be nonzero");
    end

    logic          trig_s, echo_s;
    state_t        state;
    logic [31:0]   cnt, acc, res;
    logic [PW-1:0] presc;
    logic          armed;
    logic [31:0]   cnt_inc, acc_nx, n_nx;
    logic [PW-1:0] presc_nx;
    logic          wrap, step;

    sync2 u_sync_trig (.clk(clk), .rst_n(rst_n), .d(trigger), .q(trig_s));
    sync2 u_sync_echo (.clk(clk), .rst_n(rst_n), .d(echo),    .q(echo_s));

    // cnt is shared: trigger high count in TRIG, wait count in WAIT, echo samples N in MEAS.
    // step marks every sampled echo-high cycle of a qualified measurement, including the
    // cycle that enters MEAS, so the echo count starts at 1 on entry.
    always_comb begin
        cnt_inc  = cnt + 32'd1;
        wrap     = presc == PW'(CYCLES_PER_MM - 1);
        presc_nx = wrap ? '0 : presc + 1'b1;
        acc_nx   = wrap ? acc + 32'd1 : acc;
        n_nx     = (state == S_MEAS ? cnt : 32'd0) + 32'd1;
        step     = echo_s && (state == S_WAIT || state == S_MEAS ||
                              (state == S_TRIG && !trig_s && triggerSuc));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            presc      <= '0;
            acc        <= '0;
            res        <= '0;
            armed      <= 1'b0;
            valid      <= 1'b0;
            triggerSuc <= 1'b0;
            distance   <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // armed records that trig_s was low on the previous IDLE cycle,
                    // so a trigger held high across a result cannot restart a measurement
                    armed <= !trig_s;
                    presc <= '0;
                    acc   <= '0;
                    if (trig_s && armed) begin
                        state      <= S_TRIG;
                        cnt        <= 32'd1;
                        triggerSuc <= TRIG_MIN_CYCLES <= 1;
                    end
                end
                S_TRIG: begin
                    if (trig_s) begin
                        if (cnt < TRIG_MIN_CYCLES) cnt <= cnt_inc;
                        if (cnt_inc >= TRIG_MIN_CYCLES) triggerSuc <= 1'b1;
                    end else if (!triggerSuc) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (cnt_inc >= ECHO_TIMEOUT) begin
                        state <= S_DONE;
                        res   <= DIST_TIMEOUT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_MEAS: begin
                    if (!echo_s) begin
                        state <= S_DONE;
                        res   <= acc;
                    end
                end
                S_DONE: begin
                    distance   <= res;
                    valid      <= 1'b1;
                    triggerSuc <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // An echo-high sample overrides the per-state decision above: it always
            // counts, and the measurement ends early once N hits the timeout.
            if (step) begin
                cnt   <= n_nx;
                presc <= presc_nx;
                acc   <= acc_nx;
                if (n_nx >= ECHO_TIMEOUT) begin
                    state <= S_DONE;
                    res   <= DIST_TIMEOUT;
                end else begin
                    state <= S_MEAS;
                end
            end
        end
    end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: randomized and directed checks of ultrasonic_ranger against a
// pin-level arithmetic model of each measurement (valid time, triggerSuc window, distance).
module tb_ultrasonic_ranger;
    localparam int M = 500;
    localparam int P = 291;
    localparam int T = 12000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic        echo = 1'b0;
    logic        valid;
    logic        triggerSuc;
    logic [31:0] distance;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_v = -1;
    int suc_lo = 1;
    int suc_hi = 0;
    logic [31:0] exp_dist = '0;
    logic [31:0] model_dist = '0;
    int valid_cnt = 0;
    int suc_cnt = 0;

    ultrasonic_ranger #(
        .CLK_HZ(50_000_000),
        .TRIG_MIN_CYCLES(M),
        .CYCLES_PER_MM(P),
        .ECHO_TIMEOUT(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .trigger(trigger),
        .echo(echo),
        .valid(valid),
        .triggerSuc(triggerSuc),
        .distance(distance)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    // Per-cycle comparison: outputs reflect the edge numbered cyc.
    always @(negedge clk) begin
        if (cyc == exp_v) model_dist = exp_dist;
        check("valid", 32'(valid), 32'(cyc == exp_v));
        check("triggerSuc", 32'(triggerSuc), 32'(cyc >= suc_lo && cyc <= suc_hi));
        check("distance", distance, model_dist);
        if (valid) valid_cnt++;
        if (triggerSuc) suc_cnt++;
    end

    // Pin sample k is the value held across edge k; the FSM acts on it at edge k+2.
    // tl: trigger high samples; g: samples from trigger fall to echo rise; e: echo high
    // samples (0 = echo never rises); abort_at: pull reset this many cycles into the echo.
    task automatic measure(input int tl, input int g, input int e, input int abort_at);
        int a, f, r, v, end_c;
        logic [31:0] d;
        @(posedge clk); #1;
        a = cyc + 1;
        f = a + tl;
        r = f + g;
        d = '0;
        if (tl < M) v = -1;
        else if (e == 0 || g > T) begin v = f + T + 3; d = ONES; end
        else if (e >= T) begin v = r + T + 2; d = ONES; end
        else begin v = r + e + 3; d = 32'(e / P); end
        exp_v = v;
        exp_dist = d;
        suc_lo = a + M + 1;
        suc_hi = (tl < M) ? 0 : v - 1;
        trigger = 1'b1;
        repeat (tl) @(posedge clk);
        #1 trigger = 1'b0;
        if (e > 0) begin
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            echo = 1'b1;
            if (abort_at > 0) begin
                repeat (abort_at) @(posedge clk);
                #1 rst_n = 1'b0;
                exp_v = -1;
                suc_lo = 1;
                suc_hi = 0;
                model_dist = '0;
                #1;
                check("abort_valid", 32'(valid), 32'd0);
                check("abort_suc", 32'(triggerSuc), 32'd0);
                check("abort_dist", distance, 32'd0);
                echo = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                return;
            end
            repeat (e) @(posedge clk);
            #1 echo = 1'b0;
        end
        end_c = ((v > f) ? v : f + 3) + 5;
        while (cyc < end_c) @(posedge clk);
        #1;
    endtask

    initial begin
        int vc, sc;
        #2;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_suc", 32'(triggerSuc), 32'd0);
        check("rst_dist", distance, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Echo starting with the trigger fall, one sample short of the timeout.
        vc = valid_cnt;
        sc = suc_cnt;
        measure(500, 0, T - 1, 0);
        check("lit_main_dist", distance, 32'd41);
        check("lit_main_vcnt", 32'(valid_cnt - vc), 32'd1);
        check("lit_main_suc_cycles", 32'(suc_cnt - sc), 32'd12001);

        vc = valid_cnt;
        sc = suc_cnt;
        measure(300, 0, 10000, 0);
        check("lit_short_vcnt", 32'(valid_cnt - vc), 32'd0);
        check("lit_short_suc", 32'(suc_cnt - sc), 32'd0);
        check("lit_short_dist", distance, 32'd41);

        measure(500, 4, 291, 0);
        check("lit_291", distance, 32'd1);
        measure(520, 7, 290, 0);
        check("lit_290", distance, 32'd0);

        measure(500, 0, 0, 0);
        check("lit_no_echo", distance, ONES);
        measure(500, 2, T, 0);
        check("lit_long_echo", distance, ONES);

        vc = valid_cnt;
        measure(500, 0, 2910, 1455);
        check("lit_abort_vcnt", 32'(valid_cnt - vc), 32'd0);
        measure(500, 5, 2910, 0);
        check("lit_after_rst", distance, 32'd10);

        vc = valid_cnt;
        measure(500, 3, 5820, 0);
        check("lit_b2b_20", distance, 32'd20);
        measure(500, 3, 582, 0);
        check("lit_b2b_2", distance, 32'd2);
        check("lit_b2b_vcnt", 32'(valid_cnt - vc), 32'd2);

        for (int i = 0; i < 10; i++) begin
            int tl, g, e;
            tl = $urandom_range(620, 420);
            g = $urandom_range(40, 0);
            e = $urandom_range(1500, 1);
            if ($urandom_range(3, 0) == 0) e = P * $urandom_range(5, 1) - $urandom_range(1, 0);
            measure(tl, g, e, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
